// File: rtl/pio_bus_pkg.sv
// Shared types and constants for the PIO peripheral bus master and its address decoder.
package pio_bus_pkg;

    localparam int BUS_DATA_W = 8;
    localparam int WAIT_CNT_W = 4;

    localparam logic [BUS_DATA_W-1:0] UNMAPPED_RDATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP
    } pio_state_e;

endpackage

// File: rtl/pio_addr_decode.sv
// Combinational slot-index decoder: one-hot peripheral enable plus a mapped flag.
module pio_addr_decode #(
    parameter int NUM_PERIPH = 4,
    parameter int SLOT_W     = 3
) (
    input  logic [SLOT_W-1:0]     slot,
    output logic [NUM_PERIPH-1:0] en,
    output logic                  mapped
);

    always_comb begin
        en = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            en[i] = (slot == SLOT_W'(i));
        end
    end

    // A slot index past the last peripheral matches no enable bit.
    assign mapped = |en;

endmodule

// File: rtl/pio_bus_master.sv
// Initiator for the 8-bit en/rs/rden/wren peripheral bus; one request at a time, one-cycle response pulse.
// Define PIO_BUS_ERR_EN to short-circuit unmapped slots straight to an error response.
module pio_bus_master
    import pio_bus_pkg::*;
#(
    parameter int NUM_PERIPH  = 4,
    parameter int ADDR_W      = 4,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_write,
    input  logic [BUS_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [BUS_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [NUM_PERIPH-1:0] bus_en,
    output logic                  bus_rs,
    output logic                  bus_rden,
    output logic                  bus_wren,
    output logic [BUS_DATA_W-1:0] bus_wdata,
    input  logic [BUS_DATA_W-1:0] bus_rdata
);

`ifdef PIO_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

    pio_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  write_q, write_d;
    logic                  mapped_q, mapped_d;
    logic [NUM_PERIPH-1:0] bus_en_q, bus_en_d;
    logic                  bus_rs_q, bus_rs_d;
    logic                  bus_rden_q, bus_rden_d;
    logic                  bus_wren_q, bus_wren_d;
    logic [BUS_DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [BUS_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [NUM_PERIPH-1:0] dec_en;
    logic                  dec_mapped;

    pio_addr_decode #(
        .NUM_PERIPH (NUM_PERIPH),
        .SLOT_W     (ADDR_W - 1)
    ) u_decode (
        .slot   (req_addr[ADDR_W-1:1]),
        .en     (dec_en),
        .mapped (dec_mapped)
    );

    always_comb begin
        // NOTE: every *_d starts from a default, so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        write_d     = write_q;
        mapped_d    = mapped_q;
        bus_en_d    = bus_en_q;
        bus_rs_d    = bus_rs_q;
        bus_rden_d  = bus_rden_q;
        bus_wren_d  = bus_wren_q;
        bus_wdata_d = bus_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    mapped_d = dec_mapped;
                    if (ERR_EN && !dec_mapped) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        if (!req_write) rsp_rdata_d = UNMAPPED_RDATA;
                    end else begin
                        state_d    = ACCESS;
                        wait_cnt_d = WAIT_INIT;
                        bus_en_d   = dec_en;
                        bus_rs_d   = req_addr[0];
                        bus_wren_d = req_write;
                        bus_rden_d = !req_write;
                        if (req_write) bus_wdata_d = req_wdata;
                    end
                end
            end
            ACCESS: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
                end else if (write_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    bus_en_d    = '0;
                    bus_wren_d  = 1'b0;
                    bus_rden_d  = 1'b0;
                    bus_rs_d    = 1'b0;
                end else begin
                    // Reads hold the strobes one extra cycle so bus_rdata settles before capture.
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = mapped_q ? bus_rdata : UNMAPPED_RDATA;
                bus_en_d    = '0;
                bus_wren_d  = 1'b0;
                bus_rden_d  = 1'b0;
                bus_rs_d    = 1'b0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            write_q     <= 1'b0;
            mapped_q    <= 1'b0;
            bus_en_q    <= '0;
            bus_rs_q    <= 1'b0;
            bus_rden_q  <= 1'b0;
            bus_wren_q  <= 1'b0;
            bus_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge *_d values together.
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            write_q     <= write_d;
            mapped_q    <= mapped_d;
            bus_en_q    <= bus_en_d;
            bus_rs_q    <= bus_rs_d;
            bus_rden_q  <= bus_rden_d;
            bus_wren_q  <= bus_wren_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign bus_en    = bus_en_q;
    assign bus_rs    = bus_rs_q;
    assign bus_rden  = bus_rden_q;
    assign bus_wren  = bus_wren_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_pio_bus_master.sv
// Scoreboard bench for pio_bus_master: two instances (WAIT_CYCLES 0 and 3), directed cases then random traffic.
module tb_pio_bus_master;

    typedef struct {
        logic       write;
        logic [3:0] en;
        logic       rs;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
        int         lat;
        int         nstrobe;
        int         acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int inst);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (dut %0d): got 0x%0h, want 0x%0h", name, inst, act, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int s, input int r);
        return (s == 2 && r == 0) ? 8'h3C : 8'(s * 37 + r * 91 + 5);
    endfunction

    // Expected outcome of one request, from the bus rules alone.
    function automatic exp_t predict(input logic [3:0] addr, input logic wr, input logic [7:0] wd,
                                     input int w, input logic [7:0] stored, input logic [7:0] prev_rdata);
        exp_t e;
        int   slot;
        bit   mapped;
        slot      = int'(addr[3:1]);
        mapped    = (slot < 4);
        e.write   = wr;
        e.wdata   = wd;
        e.rs      = addr[0];
        e.en      = mapped ? 4'(1 << slot) : 4'b0000;
        e.err     = 1'b0;
        e.acc_cyc = 0;
        e.lat     = wr ? 2 + w : 3 + w;
        e.nstrobe = wr ? 1 + w : 2 + w;
        e.rdata   = wr ? prev_rdata : (mapped ? stored : 8'hFF);
`ifdef PIO_BUS_ERR_EN
        if (!mapped) begin
            e.err     = 1'b1;
            e.lat     = 1;
            e.nstrobe = 0;
        end
`endif
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int WV = (g == 0) ? 0 : 3;

        logic       rst;
        logic       req_valid, req_ready, req_write;
        logic [3:0] req_addr;
        logic [7:0] req_wdata;
        logic       rsp_valid, rsp_err;
        logic [7:0] rsp_rdata;
        logic [3:0] bus_en;
        logic       bus_rs, bus_rden, bus_wren;
        logic [7:0] bus_wdata, bus_rdata;

        logic [7:0] periph_mem [4][2];
        logic [7:0] ref_mem [8][2];
        logic [7:0] exp_rdata;
        exp_t       sb_q[$];
        bit         done_g = 1'b0;
        int         last_rsp_cyc = -10;

        int         acc_n = 0;
        int         acc_first = 0;
        bit         acc_bad = 1'b0;
        logic [3:0] acc_en;
        logic       acc_rs, acc_wr;
        logic [7:0] acc_wd;

        pio_bus_master #(
            .NUM_PERIPH  (4),
            .ADDR_W      (4),
            .WAIT_CYCLES (WV)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_addr  (req_addr),
            .req_write (req_write),
            .req_wdata (req_wdata),
            .rsp_valid (rsp_valid),
            .rsp_rdata (rsp_rdata),
            .rsp_err   (rsp_err),
            .bus_en    (bus_en),
            .bus_rs    (bus_rs),
            .bus_rden  (bus_rden),
            .bus_wren  (bus_wren),
            .bus_wdata (bus_wdata),
            .bus_rdata (bus_rdata)
        );

        // Peripheral registers: latched on every edge the write strobe is up, so the final ACCESS edge wins.
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s < 4; s++)
                    for (int r = 0; r < 2; r++)
                        periph_mem[s][r] <= init_val(s, r);
            end else if (bus_wren) begin
                for (int s = 0; s < 4; s++)
                    if (bus_en[s]) periph_mem[s][bus_rs] <= bus_wdata;
            end
        end

        always_comb begin
            bus_rdata = 8'h00;
            for (int s = 0; s < 4; s++)
                if (bus_rden && bus_en[s]) bus_rdata = periph_mem[s][bus_rs];
        end

        task automatic reset_ref();
            for (int s = 0; s < 8; s++)
                for (int r = 0; r < 2; r++)
                    ref_mem[s][r] = init_val(s, r);
            exp_rdata = 8'h00;
        endtask

        task automatic issue(input logic [3:0] a, input logic wr, input logic [7:0] wd, input bit hold);
            exp_t e;
            logic r;
            int   n;
            n         = 0;
            req_valid = 1'b1;
            req_addr  = a;
            req_write = wr;
            req_wdata = wd;
            do begin
                r = req_ready;
                @(posedge clk);
                #1;
                n++;
            end while (!r && n < 100);
            if (!r) begin
                check("accept_timeout", 32'd0, 32'd1, g);
                return;
            end
            e = predict(a, wr, wd, WV, ref_mem[a[3:1]][a[0]], exp_rdata);
            e.acc_cyc = cyc;
            sb_q.push_back(e);
            if (hold) check("b2b_accept_cycle", cyc, last_rsp_cyc + 2, g);
            if (!wr) exp_rdata = e.rdata;
            else if (a[3:1] < 3'd4) ref_mem[a[3:1]][a[0]] = wd;
        endtask

        initial begin : drive
            logic [3:0] a;
            logic       wr;
            logic [7:0] wd;
            int         gap;
            int         n;
            bit         hold;
            rst       = 1'b0;
            req_valid = 1'b0;
            req_addr  = '0;
            req_write = 1'b0;
            req_wdata = '0;
            reset_ref();
            repeat (3) @(posedge clk);
            #1;
            check("reset_en", bus_en, 4'h0, g);
            check("reset_strobes", {bus_rden, bus_wren, bus_rs}, 3'b000, g);
            check("reset_rsp", {rsp_valid, rsp_err}, 2'b00, g);
            check("reset_wdata", bus_wdata, 8'h00, g);
            check("reset_rdata", rsp_rdata, 8'h00, g);
            rst = 1'b1;
            #1;
            check("reset_ready", req_ready, 1'b1, g);

            issue(4'b0011, 1'b1, 8'hA5, 1'b0);
            req_valid = 1'b0;
            issue(4'b0100, 1'b0, 8'h00, 1'b0);
            req_valid = 1'b0;
            issue(4'b1110, 1'b0, 8'h00, 1'b0);
            req_valid = 1'b0;
            issue(4'b1110, 1'b1, 8'h77, 1'b0);
            issue(4'b0101, 1'b1, 8'h5A, 1'b0);
            issue(4'b0101, 1'b0, 8'h00, 1'b1);
            req_valid = 1'b0;

            // Abort a read in its second cycle.
            issue(4'b0110, 1'b0, 8'h00, 1'b0);
            req_valid = 1'b0;
            @(posedge clk);
            #2;
            rst = 1'b0;
            #1;
            check("abort_en", bus_en, 4'h0, g);
            check("abort_strobes", {bus_rden, bus_wren}, 2'b00, g);
            check("abort_rsp_valid", rsp_valid, 1'b0, g);
            sb_q.delete();
            reset_ref();
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            check("abort_ready", req_ready, 1'b1, g);
            check("abort_rdata", rsp_rdata, 8'h00, g);

            hold = 1'b0;
            for (int i = 0; i < 60; i++) begin
                a  = 4'($urandom_range(0, 15));
                wr = 1'($urandom_range(0, 1));
                wd = 8'($urandom);
                issue(a, wr, wd, hold);
                gap = $urandom_range(0, 2);
                if (gap != 0) begin
                    req_valid = 1'b0;
                    repeat (gap) @(posedge clk);
                    #1;
                end
                hold = (gap == 0);
            end
            req_valid = 1'b0;

            n = 0;
            while (sb_q.size() != 0 && n < 100) begin
                @(posedge clk);
                n++;
            end
            check("drain", sb_q.size(), 0, g);
            done_g = 1'b1;
        end

        initial begin : monitor
            exp_t e;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    acc_n   = 0;
                    acc_bad = 1'b0;
                end else begin
                    check("req_ready", req_ready, (sb_q.size() == 0), g);
                    if (bus_rden || bus_wren || bus_en != 4'h0) begin
                        if (acc_n == 0) begin
                            acc_first = cyc;
                            acc_en    = bus_en;
                            acc_rs    = bus_rs;
                            acc_wr    = bus_wren;
                            acc_wd    = bus_wdata;
                        end else if (bus_en != acc_en || bus_rs != acc_rs || bus_wren != acc_wr ||
                                     (acc_wr && bus_wdata != acc_wd)) begin
                            acc_bad = 1'b1;
                        end
                        if (bus_rden == bus_wren) acc_bad = 1'b1;
                        acc_n++;
                    end
                    if (rsp_valid) begin
                        if (sb_q.size() == 0) begin
                            check("rsp_unexpected", 32'd1, 32'd0, g);
                        end else begin
                            e = sb_q.pop_front();
                            check("rsp_latency", cyc - e.acc_cyc + 1, e.lat, g);
                            check("rsp_err", rsp_err, e.err, g);
                            check("rsp_rdata", rsp_rdata, e.rdata, g);
                            check("strobe_cycles", acc_n, e.nstrobe, g);
                            if (e.nstrobe != 0) begin
                                check("strobe_start", acc_first, e.acc_cyc, g);
                                check("bus_en", acc_en, e.en, g);
                                check("bus_rs", acc_rs, e.rs, g);
                                check("strobe_dir", acc_wr, e.write, g);
                                check("strobe_stable", acc_bad, 1'b0, g);
                                if (e.write) check("bus_wdata", acc_wd, e.wdata, g);
                            end
                        end
                        last_rsp_cyc = cyc;
                        acc_n        = 0;
                        acc_bad      = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        fork
            wait (g_inst[0].done_g && g_inst[1].done_g);
            begin
                repeat (20000) @(posedge clk);
                check("global_timeout", 32'd0, 32'd1, -1);
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
